// File: rtl/acia_pkg.sv
// Shared types for the ACIA link arbiter: FSM states, source tags, round-robin pick.
// Source tag 0 is the ikbd queue and 1 is the midi queue.
package acia_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    PACE    = 2'd2
  } state_e;

  localparam logic SRC_IKBD = 1'b0;
  localparam logic SRC_MIDI = 1'b1;

  // Round-robin between two requesters: on contention the one not served last wins.
  function automatic logic pick_src(input logic ikbd_req, input logic midi_req,
                                    input logic last_grant);
    logic src;
    src = SRC_IKBD;
    if (ikbd_req && midi_req) begin
      src = ~last_grant;
    end else if (midi_req) begin
      src = SRC_MIDI;
    end
    return src;
  endfunction

endpackage

// File: rtl/acia_strobe_sync.sv
// Brings the io controller's asynchronous read strobe into the clk domain (2-FF) and
// emits a one-cycle pulse on each synchronised rising edge.
module acia_strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_strobe,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/acia_link_arbiter.sv
// Round-robin arbiter sharing the io controller byte channel between the ikbd and midi ACIA queues.
// Define ACIA_LINK_PACE_EN to pace grants at the serial byte rate (PACE state + down-counter).
module acia_link_arbiter
  import acia_pkg::*;
#(
  parameter int PACE_CYCLES = 11138,
  parameter int TIMER_W     = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ikbd_avail,
  input  logic [7:0] ikbd_data,
  output logic       ikbd_ack,
  input  logic       midi_avail,
  input  logic [7:0] midi_data,
  output logic       midi_ack,
  output logic       io_avail,
  output logic [7:0] io_data,
  output logic       io_src,
  input  logic       io_strobe
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_data;
  logic       r_src;
  logic       r_last_grant;
  logic       r_first;

  logic       w_strobe_pulse;
  logic       w_grant;
  logic       w_grant_src;
  logic       w_done;
  logic       w_timer_zero;

  acia_strobe_sync u_strobe_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_strobe (io_strobe),
    .o_pulse  (w_strobe_pulse)
  );

  assign w_grant_src = pick_src(ikbd_avail, midi_avail, r_last_grant);

`ifdef ACIA_LINK_PACE_EN
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_pace_last;

  assign w_timer_zero = (r_timer == '0);
  assign w_pace_last  = (r_timer <= TIMER_W'(1));

  // Saturating down-counter, reloaded when the io controller takes the byte.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_done) begin
      w_timer_nxt = TIMER_W'(PACE_CYCLES);
    end else if (r_state == PACE && !w_timer_zero) begin
      w_timer_nxt = r_timer - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_nxt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timer_zero = 1'b1;
  assign w_unused_cfg = ^{PACE_CYCLES[0], TIMER_W[0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_timer_zero && (ikbd_avail || midi_avail)) begin
          w_grant     = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (w_strobe_pulse) begin
          w_done = 1'b1;
`ifdef ACIA_LINK_PACE_EN
          w_state_nxt = PACE;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
`ifdef ACIA_LINK_PACE_EN
      PACE: begin
        // Leave on the same edge that brings the counter to zero.
        if (w_pace_last) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_data       <= 8'h00;
      r_src        <= SRC_IKBD;
      r_last_grant <= SRC_MIDI;
      r_first      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_grant;
      if (w_grant) begin
        r_src  <= w_grant_src;
        r_data <= (w_grant_src == SRC_MIDI) ? midi_data : ikbd_data;
      end
      if (w_done) begin
        r_last_grant <= r_src;
      end
    end
  end

  // The queue was popped at grant time, so a byte lost to reset is not replayed.
  assign io_avail = (r_state == PRESENT);
  assign io_data  = r_data;
  assign io_src   = r_src;
  assign ikbd_ack = r_first & (r_src == SRC_IKBD);
  assign midi_ack = r_first & (r_src == SRC_MIDI);

endmodule

// File: tb/tb_acia_link_arbiter.sv
// Scoreboard bench for acia_link_arbiter: queue models feed the DUT, a round-robin model
// predicts each presented byte, and a negedge monitor checks data, tags, acks and timing.
module tb_acia_link_arbiter;

  localparam int PACE = 24;
`ifdef ACIA_LINK_PACE_EN
  localparam int GAP = PACE + 1;
`else
  localparam int GAP = 1;
`endif

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ikbd_avail = 1'b0;
  logic [7:0] ikbd_data = 8'h00;
  logic       ikbd_ack;
  logic       midi_avail = 1'b0;
  logic [7:0] midi_data = 8'h00;
  logic       midi_ack;
  logic       io_avail;
  logic [7:0] io_data;
  logic       io_src;
  logic       io_strobe = 1'b0;

  acia_link_arbiter #(.PACE_CYCLES(PACE), .TIMER_W(14)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ikbd_avail (ikbd_avail),
    .ikbd_data  (ikbd_data),
    .ikbd_ack   (ikbd_ack),
    .midi_avail (midi_avail),
    .midi_data  (midi_data),
    .midi_ack   (midi_ack),
    .io_avail   (io_avail),
    .io_data    (io_data),
    .io_src     (io_src),
    .io_strobe  (io_strobe)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ikbd_q[$];
  logic [7:0] midi_q[$];
  exp_t       exp_q[$];
  logic       model_last = 1'b1;

  // Responder state
  bit resp_en    = 1'b0;
  int resp_fixed = -1;
  int resp_delay = 0;
  int wait_cnt   = 0;
  int hi_cnt     = 0;
  int lo_cnt     = 10;
  int rise_cyc   = 0;
  bit strobe_fired = 1'b0;

  // Monitor state
  bit   prev_avail  = 1'b0;
  bit   ack_chk     = 1'b0;
  bit   pending_gap = 1'b0;
  int   fall_cyc    = 0;
  exp_t cur;
  exp_t held;
  int   ack_total   = 0;
  int   grant_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    if (ikbd_ack && ikbd_q.size() > 0) ikbd_q.delete(0);
    if (midi_ack && midi_q.size() > 0) midi_q.delete(0);
    if (io_strobe) begin
      hi_cnt++;
      if (hi_cnt >= 3) begin
        io_strobe = 1'b0;
        lo_cnt = 0;
      end
    end else begin
      lo_cnt++;
      if (resp_en && io_avail && lo_cnt >= 3) begin
        if (wait_cnt >= resp_delay) begin
          io_strobe    = 1'b1;
          hi_cnt       = 0;
          rise_cyc     = cyc;
          strobe_fired = 1'b1;
          wait_cnt     = 0;
          resp_delay   = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 5));
        end else begin
          wait_cnt++;
        end
      end
    end
    ikbd_avail = (ikbd_q.size() > 0);
    ikbd_data  = (ikbd_q.size() > 0) ? ikbd_q[0] : 8'h00;
    midi_avail = (midi_q.size() > 0);
    midi_data  = (midi_q.size() > 0) ? midi_q[0] : 8'h00;
  endtask

  // Push a batch into both queues at once and predict the presentation order.
  task automatic load(input int ni, input int nm, input logic [7:0] di,
                      input logic [7:0] dm, input bit rnd);
    logic [7:0] li[$];
    logic [7:0] lm[$];
    exp_t e;
    for (int k = 0; k < ni; k++) begin
      li.push_back(rnd ? 8'($urandom) : di);
      ikbd_q.push_back(li[k]);
    end
    for (int k = 0; k < nm; k++) begin
      lm.push_back(rnd ? 8'($urandom) : dm);
      midi_q.push_back(lm[k]);
    end
    while (li.size() > 0 || lm.size() > 0) begin
      if (li.size() > 0 && (lm.size() == 0 || model_last == 1'b1)) begin
        e.src  = 1'b0;
        e.data = li.pop_front();
      end else begin
        e.src  = 1'b1;
        e.data = lm.pop_front();
      end
      model_last = e.src;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || io_avail || ikbd_q.size() != 0 || midi_q.size() != 0)
           && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      n_total++;
      $display("FAIL wait_idle: %0d bytes still pending after %0d cycles, required 0",
               exp_q.size(), n);
      exp_q.delete();
    end
    repeat (PACE + 4) tick();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    model_last = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_avail  = 1'b0;
      ack_chk     = 1'b0;
      pending_gap = 1'b0;
    end else begin
      ack_total += int'(ikbd_ack) + int'(midi_ack);
      if (io_avail && !prev_avail) begin
        grant_total++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_grant: io_avail rose with src %0d data %0h, required no grant",
                   io_src, io_data);
        end else begin
          cur = exp_q.pop_front();
          check("io_data", 32'(io_data), 32'(cur.data));
          check("io_src", 32'(io_src), 32'(cur.src));
          check("ikbd_ack_first", 32'(ikbd_ack), 32'(cur.src == 1'b0));
          check("midi_ack_first", 32'(midi_ack), 32'(cur.src == 1'b1));
          if (pending_gap) check("grant_gap", 32'(cyc - fall_cyc), 32'(GAP));
        end
        pending_gap = 1'b0;
        ack_chk = 1'b1;
      end else if (ack_chk) begin
        check("ack_one_cycle", 32'({ikbd_ack, midi_ack}), 32'd0);
        ack_chk = 1'b0;
      end
      if (io_avail) begin
        held.src  = io_src;
        held.data = io_data;
      end
      if (!io_avail && prev_avail) begin
        check("held_stable", 32'(held), 32'(cur));
        if (strobe_fired) check("strobe_to_fall", 32'(cyc - rise_cyc), 32'd3);
        strobe_fired = 1'b0;
        if (exp_q.size() > 0) begin
          pending_gap = 1'b1;
          fall_cyc = cyc;
        end
      end
      prev_avail = io_avail;
    end
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst_io_avail", 32'(io_avail), 32'd0);
    check("rst_io_data", 32'(io_data), 32'h00);
    check("rst_io_src", 32'(io_src), 32'd0);
    check("rst_acks", 32'({ikbd_ack, midi_ack}), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single ikbd byte, strobe after 10 cycles
    resp_en = 1'b1;
    resp_fixed = 10;
    resp_delay = 10;
    load(1, 0, 8'h80, 8'h00, 1'b0);
    wait_idle();

    // Both queues from reset: ikbd, midi, ikbd, midi
    resp_fixed = -1;
    resp_delay = 2;
    do_reset();
    load(2, 2, 8'h11, 8'h22, 1'b0);
    wait_idle();

    // Back-to-back ikbd bytes exercise the grant gap
    load(2, 0, 8'hA1, 8'h00, 1'b0);
    wait_idle();

    // Strobe pulses with nothing to present
    resp_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 0 || k == 6) begin
        io_strobe = 1'b1;
        hi_cnt = 0;
      end
      tick();
      check("idle_strobe_avail", 32'(io_avail), 32'd0);
      check("idle_strobe_acks", 32'({ikbd_ack, midi_ack}), 32'd0);
    end
    resp_en = 1'b1;
    repeat (4) tick();

    for (int p = 0; p < 8; p++) begin
      load($urandom_range(0, 4), $urandom_range(0, 4), 8'h00, 8'h00, 1'b1);
      wait_idle();
    end

    // Reset while a byte is presented
    resp_en = 1'b0;
    load(1, 0, 8'h33, 8'h00, 1'b0);
    n = 0;
    while (!io_avail && n < 200) begin
      tick();
      n++;
    end
    check("present_before_reset", 32'(io_avail), 32'd1);
    #2;
    reset_n = 1'b0;
    model_last = 1'b1;
    #1;
    check("async_rst_avail", 32'(io_avail), 32'd0);
    check("async_rst_acks", 32'({ikbd_ack, midi_ack}), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    resp_en = 1'b1;
    load(1, 1, 8'h44, 8'h55, 1'b0);
    wait_idle();

    // midi avail drops after its pop while the byte is still held
    resp_fixed = 4;
    load(0, 1, 8'h00, 8'h5A, 1'b0);
    wait_idle();

    check("ack_total", 32'(ack_total), 32'(grant_total));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
